// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(7,4) codeword layout, receiver state enum and syndrome helper
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Codeword bit indices; 1-based Hamming position is index+1.
  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_t;

  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
    logic s1, s2, s4;
    s1 = code[P1_IDX] ^ code[D0_IDX] ^ code[D1_IDX] ^ code[D3_IDX];
    s2 = code[P2_IDX] ^ code[D0_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
    s4 = code[P4_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D3_IDX];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// rtl/hamming74_correct.sv - combinational Hamming(7,4) single-error corrector
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome,
  output logic              corrected
);

  logic [CODE_W-1:0] fixed;

  always_comb begin
    syndrome  = hamming_syndrome(code);
    corrected = (syndrome != '0);
    fixed     = code;
    // Syndrome is the 1-based position of the flipped bit.
    if (corrected) fixed[syndrome - 3'd1] = ~code[syndrome - 3'd1];
    data = {fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX], fixed[D0_IDX]};
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - serial Hamming(7,4) receiver; HAMMING_RX_ERRCNT_EN adds the corrected-word counter
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_bit,
  input  logic             ser_valid,
  input  logic             ser_sof,
  output logic [3:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             corrected,
  output logic [2:0]       syndrome,
  output logic             overflow,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  rx_state_t         state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [2:0]        wire_idx, bit_idx;
  logic              capture, frame_done, load;
  logic [DATA_W-1:0] c_data;
  logic [SYN_W-1:0]  c_syn;
  logic              c_corr;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    code_d     = code_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    wire_idx   = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (ser_valid && ser_sof) begin
          capture = 1'b1;
          count_d = 3'd1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_valid) begin
          capture = 1'b1;
          if (ser_sof) begin
            count_d = 3'd1;
          end else begin
            wire_idx = count_q;
            if (count_q == 3'd6) begin
              frame_done = 1'b1;
              count_d    = 3'd0;
              state_d    = ST_IDLE;
            end else begin
              count_d = count_q + 3'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    bit_idx = (MSB_FIRST != 0) ? (3'd6 - wire_idx) : wire_idx;
    if (capture) code_d[bit_idx] = ser_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= 3'd0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      code_q  <= code_d;
    end
  end

  // Correct the word including the bit captured this cycle, so it lands on the same edge.
  hamming74_correct u_correct (
    .code      (code_d),
    .data      (c_data),
    .syndrome  (c_syn),
    .corrected (c_corr)
  );

  assign load = frame_done && (!dout_valid || dout_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 4'd0;
      dout_valid <= 1'b0;
      corrected  <= 1'b0;
      syndrome   <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        dout       <= c_data;
        corrected  <= c_corr;
        syndrome   <= c_syn;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (frame_done && !load) overflow <= 1'b1;
    end
  end

`ifdef HAMMING_RX_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (cnt_clr) begin
      err_count <= '0;
    end else if (load && c_corr && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - scoreboard bench for hamming_serial_rx against a positional Hamming model
module tb_hamming_serial_rx;

  localparam int MSB_FIRST = 0;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_bit = 1'b0;
  logic             ser_valid = 1'b0;
  logic             ser_sof = 1'b0;
  logic             dout_ready = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [3:0]       dout;
  logic             dout_valid;
  logic             corrected;
  logic [2:0]       syndrome;
  logic             overflow;
  logic [CNT_W-1:0] err_count;

  hamming_serial_rx #(.MSB_FIRST(MSB_FIRST), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_sof    (ser_sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .corrected  (corrected),
    .syndrome   (syndrome),
    .overflow   (overflow),
    .cnt_clr    (cnt_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       corr;
    logic [2:0] syn;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   m_valid, m_ovf, m_in, m_done, m_pop;
  int   m_cnt;
  bit   m_bits[$];
  logic [6:0] m_word;
  exp_t m_e, mon_e;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Syndrome as XOR of the positions of all set bits; zero for a valid codeword.
  function automatic exp_t decode(input logic [6:0] c_in);
    logic [6:0] c;
    int s;
    exp_t r;
    c = c_in;
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
    if (s != 0) c[s-1] = ~c[s-1];
    r.data = {c[6], c[5], c[4], c[2]};
    r.corr = (s != 0);
    r.syn  = s[2:0];
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    int s;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    s = 0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    return c;
  endfunction

  // Reference model: frames as bit lists, output register as a single occupancy flag.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_ovf = 0; m_in = 0; m_cnt = 0;
      m_bits.delete();
      exp_q.delete();
    end else begin
      m_pop  = m_valid && dout_ready;
      m_done = 0;
      if (ser_valid) begin
        if (ser_sof) begin
          m_bits.delete();
          m_bits.push_back(ser_bit);
          m_in = 1;
        end else if (m_in) begin
          m_bits.push_back(ser_bit);
          if (m_bits.size() == 7) begin
            m_done = 1;
            m_in   = 0;
          end
        end
      end
      if (m_done) begin
        for (int k = 0; k < 7; k++) m_word[(MSB_FIRST != 0) ? 6 - k : k] = m_bits[k];
        m_bits.delete();
        m_e = decode(m_word);
        if (!m_valid || dout_ready) begin
          exp_q.push_back(m_e);
          m_valid = 1;
          if (m_e.corr && m_cnt < CNT_MAX) m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end else if (m_pop) begin
        m_valid = 0;
      end
      if (cnt_clr) m_cnt = 0;
    end
  end

  // Monitor: compares on every falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {dout, dout_valid, corrected, syndrome, overflow, 2'(err_count)}, 32'd0);
    end else begin
      check("dout_valid", dout_valid, m_valid);
      check("overflow", overflow, m_ovf);
`ifdef HAMMING_RX_ERRCNT_EN
      check("err_count", err_count, m_cnt);
`else
      check("err_count", err_count, 0);
`endif
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("dout", dout, mon_e.data);
          check("corrected", corrected, mon_e.corr);
          check("syndrome", syndrome, mon_e.syn);
        end
      end
    end
  end

  task automatic drive(input bit b, input bit v, input bit sof);
    ser_bit = b; ser_valid = v; ser_sof = sof;
    if (rand_ready) dout_ready = 1'($urandom_range(1));
    @(posedge clk);
    #1;
    ser_valid = 0; ser_sof = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom_range(1)), 0, 1'($urandom_range(1)));
  endtask

  task automatic send_word(input logic [6:0] c, input int gap_pct, input bit rdy_last);
    for (int k = 0; k < 7; k++) begin
      if (k > 0)
        for (int g = 0; g < 3; g++)
          if (int'($urandom_range(99)) < gap_pct) drive(1'($urandom_range(1)), 0, 1'($urandom_range(1)));
      if (rdy_last && k == 6) dout_ready = 1;
      drive(c[(MSB_FIRST != 0) ? 6 - k : k], 1, k == 0);
      if (rdy_last && k == 6) dout_ready = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    logic [6:0] c;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    dout_ready = 1;

    send_word(7'h55, 0, 0);
    check("clean_latency", dout_valid, 1);
    check("clean_dout", dout, 4'hB);
    check("clean_corrected", corrected, 0);
    idle(2);

    send_word(7'h45, 0, 0);
    check("err_dout", dout, 4'hB);
    check("err_syndrome", syndrome, 3'd5);
    check("err_corrected", corrected, 1);
    idle(2);

    drive(1, 1, 1); drive(0, 1, 0); drive(1, 1, 0);
    send_word(7'h55, 0, 0);
    idle(3);

    dout_ready = 0;
    send_word(7'h55, 0, 0);
    send_word(7'h45, 0, 0);
    check("backpressure_overflow", overflow, 1);
    dout_ready = 1;
    idle(3);
    do_reset();

    dout_ready = 0;
    send_word(7'h55, 0, 0);
    send_word(7'h45, 0, 1);
    check("pulsed_no_overflow", overflow, 0);
    dout_ready = 1;
    idle(3);

    for (int i = 0; i < 5; i++) begin
      c = encode(4'($urandom_range(15)));
      c[$urandom_range(6)] ^= 1'b1;
      send_word(c, 30, 0);
    end
    idle(2);
`ifdef HAMMING_RX_ERRCNT_EN
    check("sat_count", err_count, CNT_MAX);
`endif
    cnt_clr = 1;
    idle(1);
    cnt_clr = 0;
    check("cnt_clr", err_count, 0);

    drive(1, 1, 1); drive(0, 1, 0); drive(1, 1, 0); drive(0, 1, 0);
    #3;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    idle(2);
    send_word(7'h55, 0, 0);
    check("post_reset_dout", dout, 4'hB);
    idle(2);

    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) == 0) cnt_clr = 1;
      if ($urandom_range(9) == 0) drive(1'($urandom_range(1)), 1, 0);
      cnt_clr = 0;
      if ($urandom_range(7) == 0) begin
        drive(1'($urandom_range(1)), 1, 1);
        for (int k = 0; k < int'($urandom_range(5)); k++) drive(1'($urandom_range(1)), 1, 0);
      end
      case ($urandom_range(3))
        0: c = encode(4'($urandom_range(15)));
        1, 2: begin
          c = encode(4'($urandom_range(15)));
          c[$urandom_range(6)] ^= 1'b1;
        end
        default: c = 7'($urandom_range(127));
      endcase
      send_word(c, 20, 0);
    end
    rand_ready = 0;
    dout_ready = 1;
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
